req_priority_encoder: RTL and testbench

- Sequential N-to-log2(N) encoder. It is the inverse of the one-hot SEL decoders: it converts a vector of request lines into a registered binary index.
- The index is presented with a VALID/ACK handshake and held stable until consumed.
- Intended use: interrupt and request arbitration in front of a one-hot decoder, so that Y feeds the decoder's SEL input.

---
 rtl/req_priority_encoder.sv | 62 ++++++
 tb/tb_req_priority_encoder.sv | 96 +++++++++
 2 files changed

// File: rtl/req_priority_encoder.sv
// req_priority_encoder: registered request-to-index encoder with VALID/ACK hold.
// Define REQ_ENCODER_RR_EN for round-robin selection instead of lowest-index priority.
module req_priority_encoder #(
  parameter int N = 8,
  parameter int M = $clog2(N)
) (
  input  logic         CLK,
  input  logic         N_RESET,
  input  logic [N-1:0] REQ,
  input  logic         ACK,
  output logic [M-1:0] Y,
  output logic         VALID,
  output logic         MULTI,
  output logic         PEND
);
  typedef enum logic {IDLE, HOLD} state_t;
  state_t state, state_d;
  logic [M-1:0] y_d, last, last_d, sel;
  logic multi_d;
  logic [N-1:0] mreq;
  assign VALID = state == HOLD;
  // the held grant is excluded so a still-asserted line cannot be re-granted back-to-back
  assign mreq = VALID ? REQ & ~(N'(1) << Y) : REQ;
  assign PEND = |mreq;
`ifdef REQ_ENCODER_RR_EN
  always_comb begin
    sel = '0;
    for (int i = N-1; i >= 0; i--)
      if (mreq[(int'(last) + 1 + i) % N]) sel = M'((int'(last) + 1 + i) % N);
  end
`else
  always_comb begin
    sel = '0;
    for (int i = N-1; i >= 0; i--)
      if (mreq[i]) sel = M'(i);
  end
`endif
  always_comb begin
    state_d = state;
    y_d = Y;
    multi_d = MULTI;
    last_d = last;
    if ((!VALID || ACK) && |mreq) begin
      state_d = HOLD;
      y_d = sel;
      multi_d = |(REQ & (REQ - N'(1)));
      last_d = sel;
    end else if (ACK) state_d = IDLE;
  end
  always_ff @(posedge CLK)
    if (!N_RESET) begin
      state <= IDLE;
      Y <= '0;
      MULTI <= 1'b0;
      last <= M'(N-1);
    end else begin
      state <= state_d;
      Y <= y_d;
      MULTI <= multi_d;
      last <= last_d;
    end
endmodule

// File: tb/tb_req_priority_encoder.sv
// tb_req_priority_encoder: vector table + scoreboard bench for req_priority_encoder (N=8 and N=5).
module tb_req_priority_encoder;
  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic rst_n, ack, rst5_n, ack5;
  logic [7:0] req;
  logic [4:0] req5;
  logic [2:0] y, y5;
  logic valid, multi, pend, valid5, multi5, pend5;
  req_priority_encoder #(.N(8)) dut (.CLK(clk), .N_RESET(rst_n), .REQ(req), .ACK(ack),
    .Y(y), .VALID(valid), .MULTI(multi), .PEND(pend));
  req_priority_encoder #(.N(5)) dut5 (.CLK(clk), .N_RESET(rst5_n), .REQ(req5), .ACK(ack5),
    .Y(y5), .VALID(valid5), .MULTI(multi5), .PEND(pend5));
  typedef struct { int rst; int req; int ack; int y; int yr; int v; int m; int p; } vec_t;
  typedef struct { int y; int v; int m; int p; } exp_t;
  vec_t vq[$];
  exp_t sb[$];
  exp_t e;
  int total = 0, passed = 0;
  task automatic chk(input string name, input int act, input int exp);
    total++;
    if (act == exp) passed++;
    else $display("FAIL %s: got %0d expected %0d", name, act, exp);
  endtask
  // yr is the expected Y with round-robin enabled; m=-1 skips the MULTI check
  task automatic add(input int rst, input int r, input int a, input int ey, input int eyr,
                     input int ev, input int em, input int ep);
    vq.push_back('{rst, r, a, ey, eyr, ev, em, ep});
  endtask
  initial begin
    rst_n = 1'b0; req = '0; ack = 1'b0; rst5_n = 1'b0; req5 = '0; ack5 = 1'b0;
    add(0, 'hFF, 0, 0, 0, 0, 0, 1);
    add(0, 'hFF, 0, 0, 0, 0, 0, 1);
    for (int i = 0; i < 5; i++) add(1, 'h00, 0, 0, 0, 0, 0, 0);
    add(1, 'h20, 0, 5, 5, 1, 0, 0);
    for (int i = 0; i < 4; i++) add(1, 'h00, 0, 5, 5, 1, 0, 0);
    add(1, 'h00, 1, 5, 5, 0, 0, 0);
    add(0, 'h00, 0, 0, 0, 0, 0, 0);
    add(1, 'h94, 0, 2, 2, 1, 1, 1);
    add(1, 'h90, 1, 4, 4, 1, 1, 1);
    add(1, 'h80, 1, 7, 7, 1, 0, 0);
    add(1, 'h00, 1, 7, 7, 0, 0, 0);
    add(1, 'h03, 1, 0, 0, 1, 1, 1);
    add(1, 'h03, 1, 1, 1, 1, -1, 1);
    add(1, 'h03, 1, 0, 0, 1, -1, 1);
    add(1, 'h03, 1, 1, 1, 1, -1, 1);
    add(0, 'h00, 0, 0, 0, 0, 0, 0);
    add(1, 'h07, 1, 0, 0, 1, 1, 1);
    add(1, 'h07, 1, 1, 1, 1, 1, 1);
    add(1, 'h07, 1, 0, 2, 1, 1, 1);
    add(1, 'h07, 1, 1, 0, 1, 1, 1);
    add(1, 'h07, 1, 0, 1, 1, 1, 1);
    add(1, 'h00, 1, 0, 1, 0, 1, 0);
    add(1, 'h08, 0, 3, 3, 1, 0, 0);
    add(0, 'h08, 0, 0, 0, 0, 0, 1);
    add(1, 'h08, 0, 3, 3, 1, 0, 0);
    add(1, 'h09, 1, 0, 0, 1, -1, 1);
    add(1, 'h00, 1, 0, 0, 0, -1, 0);
    add(1, 'h00, 1, 0, 0, 0, -1, 0);
    foreach (vq[i]) begin
      rst_n = 1'(vq[i].rst);
      req = 8'(vq[i].req);
      ack = 1'(vq[i].ack);
`ifdef REQ_ENCODER_RR_EN
      sb.push_back('{vq[i].yr, vq[i].v, vq[i].m, vq[i].p});
`else
      sb.push_back('{vq[i].y, vq[i].v, vq[i].m, vq[i].p});
`endif
      @(posedge clk); #1;
      e = sb.pop_front();
      chk($sformatf("row%0d Y", i), int'(y), e.y);
      chk($sformatf("row%0d VALID", i), int'(valid), e.v);
      chk($sformatf("row%0d PEND", i), int'(pend), e.p);
      if (e.m >= 0) chk($sformatf("row%0d MULTI", i), int'(multi), e.m);
    end
    for (int r = 0; r < 32; r++) begin
      int lo;
      rst5_n = 1'b0;
      @(posedge clk); #1;
      rst5_n = 1'b1;
      req5 = 5'(r);
      lo = 0;
      for (int b = 4; b >= 0; b--) if (r[b]) lo = b;
      sb.push_back('{lo, int'(r != 0), int'($countones(r) > 1), int'($countones(r) > 1)});
      @(posedge clk); #1;
      e = sb.pop_front();
      chk($sformatf("n5 req=%0d Y", r), int'(y5), e.y);
      chk($sformatf("n5 req=%0d Y<=4", r), int'(y5 <= 3'd4), 1);
      chk($sformatf("n5 req=%0d VALID", r), int'(valid5), e.v);
      chk($sformatf("n5 req=%0d MULTI", r), int'(multi5), e.m);
      chk($sformatf("n5 req=%0d PEND", r), int'(pend5), e.p);
    end
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
